uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver for the UART link: recovers 8N1 frames from the `din` line and presents each byte with a one-cycle strobe. It is the receive-side counterpart of `uart_tx` and uses the same bit period (`UART_FULL_ETU`) and the same shared UART definitions. It sits between the board RX pin and the command/packet logic.

## Interface
- `FULL_ETU`, default `UART_FULL_ETU`: bit period minus one, in clocks. 9 bits wide, must be ≥ 3.
- `HALF_ETU`, localparam = `FULL_ETU >> 1`: mid-bit offset for start-bit verification.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial line. Asynchronous to `clk`; idles high.
- `data_in`  out  8  last correctly framed byte.
- `valid`  out  1  one-cycle strobe: `data_in` updated this cycle.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low, frame discarded.

## Operation
- Input synchronizer:
  - Two flops (`din_s`) plus one history flop (`din_prev`).
  - All three reset to 1.
  - Start edge = `din_s==0 && din_prev==1`.
- Counter:
  - `etu_cnt` is 9 bits. It increments every cycle outside IDLE.
  - It is cleared on every state change and on every data-bit sample.
- State machine (states `UART_RX_IDLE`, `UART_RX_START`, `UART_RX_DATA`, `UART_RX_STOP`):
  - IDLE: on start edge, go to START and set `etu_cnt`=0. Otherwise hold `etu_cnt` at 0.
  - START: when `etu_cnt==HALF_ETU`, sample `din_s`.
    - If 0: go to DATA, `etu_cnt`=0, `bit_cnt`=0.
    - If 1: false start; return to IDLE with no strobe.
  - DATA: when `etu_cnt==FULL_ETU`:
    - Shift `shreg <= {din_s, shreg[7:1]}` (LSB first), `bit_cnt`+1, `etu_cnt`=0.
    - After the sample taken with `bit_cnt==7`, go to STOP.
  - STOP: when `etu_cnt==FULL_ETU`, sample `din_s`.
    - If 1: `data_in<=shreg`, `valid<=1`.
    - If 0: `frame_err<=1` and `data_in` is unchanged.
    - In both cases, go to IDLE.
- Strobes: `valid` and `frame_err` are deasserted on every cycle they are not set. They are never high together.
- Back-to-back frames: the return to IDLE happens at stop-bit mid-point, so a start edge immediately following the stop bit is caught.
- Break / line held low: after `frame_err`, no new frame starts until `din_s` has returned high and then fallen again (edge-based detection).
- Undefined state encoding: return to IDLE.

## Timing
- Reset (async assert): state IDLE, `etu_cnt`=0, `bit_cnt`=0, `shreg`=0, `data_in`=0, `valid`=0, `frame_err`=0, sync flops = 1. Release is synchronous to `clk`.
- Reset mid-frame aborts the frame. No strobe is issued, and `data_in` returns to 0.
- Edge numbering: edge 0 is the clock edge that first captures `din` low into sync flop 1.
  - START is entered at edge 2.
  - Start verification at edge 3+HALF_ETU.
  - Data bit i is sampled at edge 3+HALF_ETU+(i+1)(FULL_ETU+1).
  - The stop sample and the `valid`/`frame_err` register update happen at edge 3+HALF_ETU+9(FULL_ETU+1).
- Strobe width: exactly 1 cycle.
- `data_in` holds until the next good frame.
- Glitch rejection: any low pulse shorter than HALF_ETU+1 clocks (after synchronization) is rejected.

## Structure
- Shared `uart_defs.v`:
  - Add `UART_RX_IDLE`/`START`/`DATA`/`STOP` (2-bit encodings).
  - Add `UART_HALF_ETU`.
  - `UART_FULL_ETU` stays the single bit-period source shared with `uart_tx`.
- Sub-module `sync_2ff` (parameterized reset value): the two-flop synchronizer, reusable for other asynchronous inputs.
- Everything else lives in one clocked always block plus the async reset branch.

## Test plan
All scenarios use FULL_ETU=15 (HALF_ETU=7, 16 clocks per bit) unless stated otherwise.
- Byte 0xA5 with stop bit 1 -> `valid` high for exactly 1 cycle at edge 154 after the first low capture, `data_in`=0xA5, `frame_err`=0.
- 4-clock low glitch on idle line -> no `valid`/`frame_err`; FSM back in IDLE at edge 10. A following 0x3C frame is received correctly.
- 0x12 with stop bit driven 0 -> `frame_err` 1-cycle pulse, `data_in` remains 0xA5 from the prior frame. Line then held low for 40 clocks, released, then 0x7E sent -> exactly one `valid` with 0x7E.
- 0x00 then 0xFF back-to-back (start of second frame immediately after the first stop bit) -> two `valid` pulses 160 cycles apart, data 0x00 then 0xFF.
- `rst` pulled low during data bit 4 of 0x99 -> outputs 0 immediately, no strobe. After release, 0x3C is received correctly.
- Loopback from `uart_tx` (same FULL_ETU) sending 0x00, 0x55, 0xAA, 0xFF -> four `valid` pulses with matching data and no `frame_err`.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared UART definitions: bit period and receiver state codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  // Bit period minus one, in clocks; single source shared with uart_tx.
  localparam logic [8:0] UART_FULL_ETU = 9'd433;
  // Mid-bit offset used to verify the start bit.
  localparam logic [8:0] UART_HALF_ETU = UART_FULL_ETU >> 1;

  typedef enum logic [1:0] {
    UART_RX_IDLE  = 2'd0,
    UART_RX_START = 2'd1,
    UART_RX_DATA  = 2'd2,
    UART_RX_STOP  = 2'd3
  } uart_rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for one asynchronous input, with a
//               parameterized reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the asynchronous input through two stages.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchronizer flops, forced to the idle level while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Detects the start edge, verifies it at
//               mid-bit, samples eight data bits LSB first and checks the
//               stop bit, issuing a one-cycle valid or frame_err strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [8:0] FULL_ETU = UART_FULL_ETU
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_in,
  output logic       valid,
  output logic       frame_err
);

  localparam logic [8:0] HALF_ETU = FULL_ETU >> 1;

  logic           din_s;
  logic           din_prev_q, din_prev_d;
  uart_rx_state_e state_q, state_d;
  logic [8:0]     etu_cnt_q, etu_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           frame_err_q, frame_err_d;

  logic           start_edge;
  logic           etu_half;
  logic           etu_full;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_din_sync (
    .clk  (clk),
    .rst_n(rst),
    .d    (din),
    .q    (din_s)
  );

  // Edge-based start detection: a line held low (break) never retriggers.
  assign start_edge = !din_s && din_prev_q;
  assign etu_half   = (etu_cnt_q == HALF_ETU);
  assign etu_full   = (etu_cnt_q == FULL_ETU);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UART_RX_IDLE;
      din_prev_q  <= 1'b1;
      etu_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_prev_q  <= din_prev_d;
      etu_cnt_q   <= etu_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic; a false start falls straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UART_RX_IDLE:  if (start_edge) state_d = UART_RX_START;
      UART_RX_START: if (etu_half) state_d = din_s ? UART_RX_IDLE : UART_RX_DATA;
      UART_RX_DATA:  if (etu_full && (bit_cnt_q == 3'd7)) state_d = UART_RX_STOP;
      UART_RX_STOP:  if (etu_full) state_d = UART_RX_IDLE;
      default:       state_d = UART_RX_IDLE;
    endcase
  end

  // Counters, shift register and strobes; leaving STOP at mid-bit lets a
  // start edge right after the stop bit be caught.
  always_comb begin
    din_prev_d  = din_s;
    etu_cnt_d   = (state_q == UART_RX_IDLE) ? 9'd0 : etu_cnt_q + 9'd1;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      UART_RX_START: begin
        if (etu_half && !din_s) bit_cnt_d = 3'd0;
      end
      UART_RX_DATA: begin
        if (etu_full) begin
          shreg_d   = {din_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          etu_cnt_d = 9'd0;
        end
      end
      UART_RX_STOP: begin
        if (etu_full) begin
          if (din_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
    if (state_d != state_q) etu_cnt_d = 9'd0;
  end

  assign data_in   = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire
